// File: rtl/datapath_sequencer.sv
// Micro-sequencer that steps a small instruction memory into a register-file/ALU datapath,
// spending one SETUP cycle and one EXEC (write) cycle on each instruction.
module datapath_sequencer #(
  parameter int PROG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [2:0] prog_addr,
  input  logic [8:0] prog_data,
  input  logic [3:0] prog_len,
  input  logic       halt_on_zero,
  input  logic       start,
  input  logic       Zero,
  output logic       wr,
  output logic [2:0] ALUControl,
  output logic [1:0] addr1,
  output logic [1:0] addr2,
  output logic [1:0] addr3,
  output logic       busy,
  output logic       done,
  output logic [7:0] zero_log,
  output logic [3:0] exec_count
);

  typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [8:0] instr_q, instr_d;
  logic [3:0] len_q, len_d;
  logic [7:0] zero_log_q, zero_log_d;
  logic [3:0] exec_count_q, exec_count_d;
  logic [8:0] mem_q [PROG_DEPTH];
  logic [8:0] mem_d [PROG_DEPTH];
  logic [3:0] eff_len;
  logic       active;

  assign eff_len = (prog_len > 4'(PROG_DEPTH)) ? 4'(PROG_DEPTH) : prog_len;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    len_d        = len_q;
    zero_log_d   = zero_log_q;
    exec_count_d = exec_count_q;
    mem_d        = mem_q;

    if (prog_we && (state_q == IDLE || state_q == DONE)) begin
      mem_d[prog_addr] = prog_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          zero_log_d   = 8'd0;
          exec_count_d = 4'd0;
          len_d        = eff_len;
          pc_d         = 3'd0;
          if (eff_len == 4'd0) begin
            state_d = DONE;
          end else begin
            // Latch from mem_d so a write on the start edge is already visible
            instr_d = mem_d[0];
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = EXEC;
      end
      EXEC: begin
        zero_log_d[pc_q] = Zero;
        exec_count_d     = exec_count_q + 4'd1;
        if (({1'b0, pc_q} == (len_q - 4'd1)) || (halt_on_zero && Zero)) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + 3'd1;
          instr_d = mem_q[pc_q + 3'd1];
          state_d = SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= 3'd0;
      instr_q      <= 9'd0;
      len_q        <= 4'd0;
      zero_log_q   <= 8'd0;
      exec_count_q <= 4'd0;
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= 9'd0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      len_q        <= len_d;
      zero_log_q   <= zero_log_d;
      exec_count_q <= exec_count_d;
      mem_q        <= mem_d;
    end
  end

  // Every output decodes registered state only, so reset clears them without a clock edge
  assign active     = (state_q == SETUP) || (state_q == EXEC);
  assign wr         = (state_q == EXEC);
  assign busy       = active;
  assign done       = (state_q == DONE);
  assign ALUControl = active ? instr_q[8:6] : 3'd0;
  assign addr1      = active ? instr_q[5:4] : 2'd0;
  assign addr2      = active ? instr_q[3:2] : 2'd0;
  assign addr3      = active ? instr_q[1:0] : 2'd0;
  assign zero_log   = zero_log_q;
  assign exec_count = exec_count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed scenarios plus randomized runs
// compared against a cycle-numbered reference model of the run schedule.
module tb_datapath_sequencer;

  logic       clk;
  logic       rst;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [8:0] prog_data;
  logic [3:0] prog_len;
  logic       halt_on_zero;
  logic       start;
  logic       Zero;
  logic       wr;
  logic [2:0] ALUControl;
  logic [1:0] addr1;
  logic [1:0] addr2;
  logic [1:0] addr3;
  logic       busy;
  logic       done;
  logic [7:0] zero_log;
  logic [3:0] exec_count;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0]  model_mem [8];
  logic [11:0] obs_bus;

  assign obs_bus = {wr, busy, done, ALUControl, addr1, addr2, addr3};

  datapath_sequencer #(.PROG_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_len     (prog_len),
    .halt_on_zero (halt_on_zero),
    .start        (start),
    .Zero         (Zero),
    .wr           (wr),
    .ALUControl   (ALUControl),
    .addr1        (addr1),
    .addr2        (addr2),
    .addr3        (addr3),
    .busy         (busy),
    .done         (done),
    .zero_log     (zero_log),
    .exec_count   (exec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge
  task automatic write_entry(input logic [2:0] a, input logic [8:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Model: n instructions execute (clamped length, cut short by a halting Zero);
  // instruction k is SETUP in cycle 2k+1, EXEC in cycle 2k+2, done lands in cycle 2n+1
  task automatic run_program(input string name, input int len, input bit halt,
                             input logic [7:0] zvec, input int inject,
                             input bit co_write, input logic [8:0] co_data);
    int          eff;
    int          n;
    int          k;
    logic [7:0]  exp_log;
    logic [11:0] exp_v;
    logic        is_exec;

    if (co_write) model_mem[0] = co_data;
    eff = (len > 8) ? 8 : len;
    n = 0;
    exp_log = 8'd0;
    for (int i = 0; i < eff; i++) begin
      n++;
      exp_log[i] = zvec[i];
      if (halt && zvec[i]) break;
    end

    prog_len     = 4'(len);
    halt_on_zero = halt;
    start        = 1'b1;
    if (co_write) begin
      prog_we   = 1'b1;
      prog_addr = 3'd0;
      prog_data = co_data;
    end
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;

    for (int c = 1; c <= 2 * n + 1; c++) begin
      if (c <= 2 * n) begin
        k       = (c - 1) / 2;
        is_exec = ((c % 2) == 0);
        exp_v   = {is_exec, 1'b1, 1'b0, model_mem[k]};
        Zero    = is_exec ? zvec[k] : 1'($urandom);
      end else begin
        exp_v = {3'b001, 9'd0};
        Zero  = 1'($urandom);
      end
      chk($sformatf("%s cycle %0d", name, c), 32'(obs_bus), 32'(exp_v));
      if (c == inject) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 3'($urandom);
        prog_data = 9'($urandom);
      end
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
    end

    Zero = 1'b0;
    chk($sformatf("%s idle outputs", name), 32'(obs_bus), 32'd0);
    chk($sformatf("%s exec_count", name), 32'(exec_count), 32'(n));
    chk($sformatf("%s zero_log", name), 32'(zero_log), 32'(exp_log));
    @(negedge clk);
    chk($sformatf("%s zero_log held", name), 32'(zero_log), 32'(exp_log));
    chk($sformatf("%s exec_count held", name), 32'(exec_count), 32'(n));
  endtask

  initial begin
    logic [7:0] zv;
    int         len;
    bit         halt;

    rst          = 1'b0;
    prog_we      = 1'b0;
    prog_addr    = 3'd0;
    prog_data    = 9'd0;
    prog_len     = 4'd0;
    halt_on_zero = 1'b0;
    start        = 1'b0;
    Zero         = 1'b0;
    for (int i = 0; i < 8; i++) model_mem[i] = 9'd0;

    #1;
    chk("reset outputs", 32'(obs_bus), 32'd0);
    chk("reset zero_log", 32'(zero_log), 32'd0);
    chk("reset exec_count", 32'(exec_count), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_program("len0", 0, 1'b0, 8'hFF, 0, 1'b0, 9'd0);

    write_entry(3'd0, 9'h018);
    write_entry(3'd1, 9'h0AD);
    write_entry(3'd2, 9'h0E3);
    write_entry(3'd3, 9'h05E);
    run_program("basic4", 4, 1'b0, 8'($urandom), 0, 1'b0, 9'd0);
    run_program("halt2", 4, 1'b1, 8'b0000_0010, 0, 1'b0, 9'd0);
    run_program("cowrite", 4, 1'b0, 8'($urandom), 0, 1'b1, 9'($urandom));
    run_program("inject3", 4, 1'b0, 8'($urandom), 3, 1'b0, 9'd0);
    run_program("after_inject", 4, 1'b0, 8'($urandom), 0, 1'b0, 9'd0);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 3; j++) begin
        write_entry(3'($urandom), 9'($urandom));
      end
      len  = int'($urandom_range(0, 12));
      halt = 1'($urandom);
      zv   = 8'($urandom & $urandom);
      run_program($sformatf("rand%0d", r), len, halt, zv, 0, 1'b0, 9'd0);
    end

    // Abort mid-EXEC: outputs must clear without a clock edge
    prog_len     = 4'd4;
    halt_on_zero = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-abort exec", 32'(obs_bus), 32'({3'b110, model_mem[0]}));
    #2;
    rst = 1'b0;
    #1;
    chk("abort outputs", 32'(obs_bus), 32'd0);
    chk("abort exec_count", 32'(exec_count), 32'd0);
    chk("abort zero_log", 32'(zero_log), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("in reset %0d", c), 32'(obs_bus), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model_mem[i] = 9'd0;
    @(negedge clk);
    chk("post-reset idle", 32'(obs_bus), 32'd0);
    run_program("len12_cleared", 12, 1'b0, 8'($urandom), 0, 1'b0, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
